// File: rtl/mips_mc_ctrl.sv
// Multi-cycle sequencing controller for the MIPS core.
// Steps one shared memory port, the register file and the ALU through
// fetch / decode / execute / memory / writeback, one phase per clock.
// Illegal opcodes and memory wait timeouts park the core in a sticky trap.
module mips_mc_ctrl #(
    parameter int WAIT_LIMIT = 255,
    parameter int RETIRE_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_source,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [5:0]          alu_control,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                instr_done,
    output logic [RETIRE_W-1:0] retired,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_SUB  = 6'b100010;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // Last wait count before a still-low mem_ready becomes a bus timeout.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    state_t                state;
    logic [7:0]            wait_cnt;
    logic [RETIRE_W-1:0]   retired_q;
    logic                  trap_q;
    logic [1:0]            cause_q;

    logic                  mem_phase;
    logic                  timeout;
    logic                  done;

    assign mem_phase = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout   = mem_phase && !mem_ready && (wait_cnt == WAIT_LAST);

    // Sequencer: state, wait counter, retire counter and sticky trap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            retired_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= '0;
        end else begin
            // Counter only survives consecutive stalled cycles, so every
            // memory phase is entered with a zero count.
            wait_cnt <= (mem_phase && !mem_ready && !timeout) ? wait_cnt + 8'd1 : '0;
            if (done)
                retired_q <= retired_q + RETIRE_W'(1);
            if (timeout) begin
                state   <= S_TRAP;
                trap_q  <= 1'b1;
                cause_q <= CAUSE_TIMEOUT;
            end else begin
                case (state)
                    S_FETCH:    if (mem_ready) state <= S_DECODE;
                    S_DECODE: begin
                        case (opcode)
                            OP_RTYPE:     state <= S_EXEC_R;
                            OP_ADDI:      state <= S_EXEC_I;
                            OP_LW, OP_SW: state <= S_MEM_ADDR;
                            OP_BEQ:       state <= S_BRANCH;
                            OP_J:         state <= S_JUMP;
                            default: begin
                                state   <= S_TRAP;
                                trap_q  <= 1'b1;
                                cause_q <= CAUSE_ILLEGAL;
                            end
                        endcase
                    end
                    S_EXEC_R:   state <= S_WB_R;
                    S_EXEC_I:   state <= S_WB_I;
                    S_MEM_ADDR: state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                    S_MEM_RD:   if (mem_ready) state <= S_WB_MEM;
                    S_MEM_WR:   if (mem_ready) state <= S_FETCH;
                    S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP:
                                state <= S_FETCH;
                    S_TRAP:     state <= S_TRAP;
                    default:    state <= S_FETCH;
                endcase
            end
        end
    end

    // Control decode from the current state; reset blanks every output.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_source   = 2'd0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        alu_control = ALU_ADD;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        done        = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'd3;
            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_control = funct;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                done      = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                done      = 1'b1;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                done       = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                done    = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_source   = 2'd1;
                pc_write    = zero;
                done        = 1'b1;
            end
            S_JUMP: begin
                pc_source = 2'd2;
                pc_write  = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
        instr_done = done;
        retired    = retired_q;
        trap       = trap_q;
        trap_cause = cause_q;
        if (rst) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            iord        = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_source   = 2'd0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'd0;
            alu_control = 6'd0;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            instr_done  = 1'b0;
            retired     = '0;
            trap        = 1'b0;
            trap_cause  = 2'd0;
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: stimulus pushes one expected record per
// retired or trapping instruction, a negedge monitor accumulates per-instruction
// activity and compares it when instr_done pulses or trap rises.
module tb_mips_mc_ctrl;

    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    opcode = '0;
    logic [5:0]    funct = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b1;
    logic          mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]    pc_source;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [5:0]    alu_control;
    logic          reg_write, reg_dst, mem_to_reg, instr_done;
    logic [RW-1:0] retired;
    logic          trap;
    logic [1:0]    trap_cause;

    mips_mc_ctrl #(.WAIT_LIMIT(4), .RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .instr_done(instr_done), .retired(retired), .trap(trap),
        .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    // kind: 1 = retired via instr_done, 2 = trap entry
    typedef struct {
        int kind; int cause; int cyc; int ir; int rw; int m2r; int rd;
        int pw; int pb; int pj; int sub; int fn; int wr; int ret;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int kind, input int cause, input int cyc,
                                input int ir, input int rw, input int m2r, input int rd,
                                input int pw, input int pb, input int pj, input int sub,
                                input int fn, input int wr, input int ret);
        exp_t e;
        e.kind = kind; e.cause = cause; e.cyc = cyc; e.ir = ir; e.rw = rw;
        e.m2r = m2r; e.rd = rd; e.pw = pw; e.pb = pb; e.pj = pj; e.sub = sub;
        e.fn = fn; e.wr = wr; e.ret = ret;
        return e;
    endfunction

    // Monitor / scoreboard
    int   c_cyc, c_ir, c_rw, c_m2r, c_rd, c_pw, c_pb, c_pj, c_sub, c_fn, c_wr;
    logic prev_trap;
    int   trap_ret;

    task automatic clear_counts();
        c_cyc = 0; c_ir = 0; c_rw = 0; c_m2r = 0; c_rd = 0; c_pw = 0;
        c_pb = 0; c_pj = 0; c_sub = 0; c_fn = 0; c_wr = 0;
    endtask

    initial begin
        exp_t e;
        clear_counts();
        prev_trap = 1'b0;
        trap_ret  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs",
                    int'({mem_req, mem_we, iord, ir_write, pc_write, pc_source,
                          alu_src_a, alu_src_b, alu_control, reg_write, reg_dst,
                          mem_to_reg, instr_done, retired, trap, trap_cause}), 0);
                clear_counts();
                prev_trap = 1'b0;
            end else begin
                c_cyc++;
                if (ir_write) c_ir++;
                if (reg_write) begin
                    c_rw++;
                    if (mem_to_reg) c_m2r++;
                    if (reg_dst) c_rd++;
                end
                if (pc_write) begin
                    c_pw++;
                    if (pc_source == 2'd1) c_pb++;
                    if (pc_source == 2'd2) c_pj++;
                end
                if (alu_control == 6'b100010) c_sub++;
                if (alu_control == funct) c_fn++;
                if (mem_req && mem_we && mem_ready) c_wr++;
                if (trap) begin
                    if (!prev_trap) trap_ret = int'(retired);
                    chk("trap_quiet", int'({mem_req, mem_we, instr_done, ir_write,
                                            pc_write, reg_write}), 0);
                    chk("trap_retired", int'(retired), trap_ret);
                end
                if (instr_done || (trap && !prev_trap)) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: done=%0d trap=%0d with no expectation queued",
                                 instr_done, trap);
                    end else begin
                        e = q.pop_front();
                        chk("event_kind", instr_done ? 1 : 2, e.kind);
                        chk("trap_cause", int'(trap_cause), e.cause);
                        chk("cycles", c_cyc, e.cyc);
                        chk("ir_write_count", c_ir, e.ir);
                        chk("reg_write_count", c_rw, e.rw);
                        chk("mem_to_reg_writes", c_m2r, e.m2r);
                        chk("reg_dst_writes", c_rd, e.rd);
                        chk("pc_write_count", c_pw, e.pw);
                        chk("pc_write_branch", c_pb, e.pb);
                        chk("pc_write_jump", c_pj, e.pj);
                        chk("alu_sub_cycles", c_sub, e.sub);
                        chk("alu_funct_cycles", c_fn, e.fn);
                        chk("mem_write_accepts", c_wr, e.wr);
                        chk("retired", int'(retired), e.ret);
                        clear_counts();
                    end
                end
                prev_trap = trap;
            end
        end
    end

    // Stimulus
    task automatic step(input logic rdy);
        mem_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        mem_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // fw fetch stall cycles, k cycles after fetch, mw memory stall cycles, rest tail cycles
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int k, input int mw, input int rest,
                       input exp_t e);
        opcode = op;
        funct  = fn;
        zero   = z;
        q.push_back(e);
        repeat (fw) step(1'b0);
        step(1'b1);
        repeat (k) step(1'b1);
        repeat (mw) step(1'b0);
        repeat (rest) step(1'b1);
    endtask

    initial begin
        do_reset(3);
        //                  kind cause cyc ir rw m2r rd pw pb pj sub fn wr ret
        run(6'b001000, 6'b000000, 1'b0, 0, 3, 0, 0, mk(1, 0, 4, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        run(6'b000000, 6'b100010, 1'b0, 0, 3, 0, 0, mk(1, 0, 4, 1, 1, 0, 1, 1, 0, 0, 1, 1, 0, 1));
        run(6'b100011, 6'b000000, 1'b0, 3, 2, 2, 2, mk(1, 0, 10, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 2));
        run(6'b000100, 6'b000000, 1'b1, 0, 2, 0, 0, mk(1, 0, 3, 1, 0, 0, 0, 2, 1, 0, 1, 0, 0, 3));
        run(6'b000100, 6'b000000, 1'b0, 0, 2, 0, 0, mk(1, 0, 3, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 4));
        run(6'b000010, 6'b000000, 1'b0, 0, 2, 0, 0, mk(1, 0, 3, 1, 0, 0, 0, 2, 0, 1, 0, 0, 0, 5));
        run(6'b101011, 6'b000000, 1'b0, 0, 2, 1, 1, mk(1, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 6));
        run(6'b000000, 6'b100101, 1'b0, 0, 3, 0, 0, mk(1, 0, 4, 1, 1, 0, 1, 1, 0, 0, 0, 1, 0, 7));
        run(6'b000010, 6'b000000, 1'b0, 0, 2, 0, 0, mk(1, 0, 3, 1, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0));
        run(6'b001000, 6'b000000, 1'b0, 0, 3, 0, 0, mk(1, 0, 4, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1));

        // Reset in the writeback cycle of an R-type abandons it.
        opcode = 6'b000000;
        funct  = 6'b100100;
        repeat (3) step(1'b1);
        do_reset(2);
        run(6'b001000, 6'b000000, 1'b0, 0, 3, 0, 0, mk(1, 0, 4, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        // Illegal opcode traps after decode and stays quiet until reset.
        run(6'b111111, 6'b000000, 1'b0, 0, 1, 0, 0, mk(2, 1, 3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        repeat (4) step(1'b1);
        do_reset(2);

        // Store whose memory never answers: timeout after four stalled cycles.
        run(6'b101011, 6'b000000, 1'b0, 0, 2, 4, 0, mk(2, 2, 8, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        repeat (3) step(1'b0);
        repeat (2) step(1'b1);
        do_reset(2);

        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle sequencing controller for the MIPS core. It replaces single-cycle decode with a state machine that steps one shared memory port, the register file, and the 32-bit ALU through fetch, decode, execute, memory and writeback, one phase per clock. Memory is accessed over a req/ready handshake with bounded wait states. Illegal opcodes and memory timeouts halt the core in a sticky trap.

## Interface
Parameters:
- WAIT_LIMIT, 255: max cycles to wait for mem_ready before bus-error trap (1..255)
- RETIRE_W, 32: width of retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- opcode  in  6  instruction[31:26] from instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write (valid with mem_req)
- iord  out  1  0 = address from PC, 1 = from ALU-out register
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_source  out  2  0 = ALU result, 1 = ALU-out register (branch target), 2 = jump address
- alu_src_a  out  1  0 = PC, 1 = register read_data1
- alu_src_b  out  2  0 = read_data2, 1 = constant 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- alu_control  out  6  ALU operation code
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 = rt [20:16], 1 = rd [15:11]
- mem_to_reg  out  1  0 = ALU-out, 1 = memory data register
- instr_done  out  1  one-cycle pulse on final cycle of each instruction
- retired  out  RETIRE_W  instructions retired since reset
- trap  out  1  sticky halt flag
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = bus timeout

## Operation
- Opcodes: RTYPE 000000, ADDI 001000, J 000010, LW 100011, SW 101011, BEQ 000100; all others illegal.
- alu_control: ADD 100000, SUB 100010. R-type execute passes funct unchanged. Every other phase uses ADD, except BEQ, which uses SUB.
- States and transitions:
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1. When mem_ready=1: ir_write=1, pc_write=1, pc_source=0, then go to DECODE. Otherwise hold.
  - DECODE: alu_src_a=0, alu_src_b=3 (branch target into ALU-out). Dispatch by opcode: RTYPE->EXEC_R, ADDI->EXEC_I, LW/SW->MEM_ADDR, BEQ->BRANCH, J->JUMP, illegal->TRAP (cause 1).
  - EXEC_R: alu_src_a=1, alu_src_b=0, alu_control=funct, then go to WB_R.
  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, done; go to FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=2, then go to WB_I.
  - WB_I: reg_write=1, reg_dst=0, mem_to_reg=0, done.
  - MEM_ADDR: alu_src_a=1, alu_src_b=2. LW->MEM_RD, SW->MEM_WR.
  - MEM_RD: mem_req=1, iord=1. When mem_ready=1, go to WB_MEM.
  - WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1, done.
  - MEM_WR: mem_req=1, mem_we=1, iord=1. When mem_ready=1, done.
  - BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_source=1, pc_write=zero, done.
  - JUMP: pc_source=2, pc_write=1, done.
  - TRAP: all enables 0, mem_req=0. Held until rst.
- "done" means instr_done=1 this cycle, retired increments by 1 (wraps modulo 2^RETIRE_W), and the next state is FETCH.
- Wait counter: cleared on entry to any mem_req state. Increments each cycle mem_req=1 and mem_ready=0. If the count reaches WAIT_LIMIT with mem_ready still 0, go to TRAP with cause 2 and drop mem_req the next cycle. mem_ready=1 on the WAIT_LIMIT-th cycle still completes normally.
- mem_ready while mem_req=0 is ignored.
- Outputs not listed for a state are 0.

## Timing
- Reset: state=FETCH, retired=0, trap=0, trap_cause=0, wait counter=0.
- While rst=1, all outputs are forced to 0.
- The first mem_req is asserted in the cycle after rst deasserts.
- Outputs are decoded from the current state. ir_write and pc_write in FETCH, and pc_write in BRANCH, are also gated by same-cycle inputs (mem_ready, zero).
- Cycles per instruction with zero wait states: RTYPE 4, ADDI 4, LW 5, SW 4, BEQ 3, J 3.
- Each low mem_ready cycle adds one cycle.
- rst mid-instruction abandons the instruction: no write enables that cycle, no retire.
- Trap entry cycle: no instr_done, retired unchanged.

## Test plan
- rst 3 cycles, mem_ready tied 1, ADDI then RTYPE funct 100010 -> mem_req high the cycle after rst falls; instr_done at cycles 4 and 8; alu_control 100010 in EXEC_R; retired=2.
- LW with mem_ready low 3 cycles in FETCH and 2 cycles in MEM_RD -> 10 cycles total; ir_write exactly once; reg_write with mem_to_reg=1 once.
- BEQ with zero=1, then BEQ with zero=0 -> pc_write with pc_source=1 only in the first; each takes 3 cycles and retires.
- J -> pc_write=1, pc_source=2 on cycle 3; next cycle is FETCH.
- Opcode 111111 -> trap=1, trap_cause=1 the cycle after DECODE; no mem_req afterwards; retired unchanged; rst clears trap.
- WAIT_LIMIT=4, mem_ready held 0 in MEM_WR -> trap_cause=2 after 4 wait cycles; mem_we drops; no instr_done.
